// File: rtl/ae_mem_pkg.sv
// Shared definitions for the autoencoder sectored memory control path.
package ae_mem_pkg;

  localparam int DEF_N_SECTORS = 16;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_SEL_W     = $clog2(DEF_N_SECTORS);

  // Sector index for the default memory geometry.
  typedef logic [DEF_SEL_W-1:0] sector_t;

  // Write sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wsc_state_e;

endpackage

// File: rtl/sector_onehot_dec.sv
// Combinational sector index to one-hot decoder. Indices at or beyond
// N_SECTORS, or a low valid, produce an all-zero output.
module sector_onehot_dec #(
  parameter int N_SECTORS = 16,
  parameter int SEL_W     = $clog2(N_SECTORS)
) (
  input  logic [SEL_W-1:0]     idx,
  input  logic                 vld,
  output logic [N_SECTORS-1:0] onehot
);

  // Compare against every legal index so out-of-range values decode to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_SECTORS; i++) begin
      if (vld && (idx == SEL_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_sector_ctrl.sv
// Protection-aware sequenced write-enable generator for the sectored
// weight/activation memory. One sector per cycle, wrapping at the top,
// with locked sectors suppressed and counted as violations.
module write_sector_ctrl
  import ae_mem_pkg::*;
#(
  parameter int N_SECTORS = DEF_N_SECTORS,
  parameter int SEL_W     = $clog2(N_SECTORS),
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_write,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_W-1:0]     req_sector,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 lock_we,
  input  logic [N_SECTORS-1:0] lock_mask_in,
  output logic [N_SECTORS-1:0] lock_mask,
  output logic [N_SECTORS-1:0] enable_write,
  output logic                 busy,
  output logic                 done,
  output logic                 viol,
  output logic [CNT_W-1:0]     viol_cnt,
  output logic                 abort
);

  wsc_state_e           state_q, state_d;
  logic [SEL_W-1:0]     cur_q, cur_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [N_SECTORS-1:0] lock_mask_q, lock_mask_d;
  logic [N_SECTORS-1:0] enable_write_q, enable_write_d;
  logic                 done_q, done_d;
  logic                 viol_q, viol_d;
  logic                 abort_q, abort_d;
  logic [CNT_W-1:0]     viol_cnt_q, viol_cnt_d;

  logic [SEL_W-1:0]     beat_sel;
  logic [N_SECTORS-1:0] beat_dec;
  logic [N_SECTORS-1:0] beat_oh;
  logic                 beat_locked;
  logic                 start_ok;

  // Explicit wrap compare so non-power-of-two sector counts wrap correctly.
  function automatic logic [SEL_W-1:0] next_sector(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(N_SECTORS - 1)) ? '0 : s + 1'b1;
  endfunction

  // The beat being registered this edge comes from the request when idle,
  // otherwise from the running sector pointer.
  assign beat_sel  = (state_q == IDLE) ? req_sector : cur_q;
  assign start_ok  = ({1'b0, req_sector} < (SEL_W + 1)'(N_SECTORS));
  assign req_ready = (state_q == IDLE) && en_write;

  sector_onehot_dec #(
    .N_SECTORS (N_SECTORS),
    .SEL_W     (SEL_W)
  ) u_dec (
    .idx    (beat_sel),
    .vld    (1'b1),
    .onehot (beat_dec)
  );

  // A beat is locked when its decoded sector overlaps the current mask;
  // the mask used is the one held before any same-edge load.
  assign beat_locked = |(beat_dec & lock_mask_q);
  assign beat_oh     = beat_locked ? '0 : beat_dec;

  // Next-state and registered-output computation; outputs default to idle.
  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    rem_d          = rem_q;
    enable_write_d = '0;
    done_d         = 1'b0;
    viol_d         = 1'b0;
    abort_d        = 1'b0;
    lock_mask_d    = lock_we ? lock_mask_in : lock_mask_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (start_ok) begin
            state_d        = BURST;
            enable_write_d = beat_oh;
            viol_d         = beat_locked;
            done_d         = (req_len == '0);
            cur_d          = next_sector(req_sector);
            rem_d          = req_len;
          end else begin
            viol_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (rem_q == '0) begin
          // The last beat is on display; a completed burst is never aborted.
          state_d = IDLE;
        end else if (!en_write) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          enable_write_d = beat_oh;
          viol_d         = beat_locked;
          done_d         = (rem_q == LEN_W'(1));
          rem_d          = rem_q - 1'b1;
          cur_d          = next_sector(cur_q);
        end
      end
      default: state_d = IDLE;
    endcase

    viol_cnt_d = (viol_d && (viol_cnt_q != '1)) ? viol_cnt_q + 1'b1 : viol_cnt_q;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      rem_q          <= '0;
      lock_mask_q    <= '0;
      enable_write_q <= '0;
      done_q         <= 1'b0;
      viol_q         <= 1'b0;
      abort_q        <= 1'b0;
      viol_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      rem_q          <= rem_d;
      lock_mask_q    <= lock_mask_d;
      enable_write_q <= enable_write_d;
      done_q         <= done_d;
      viol_q         <= viol_d;
      abort_q        <= abort_d;
      viol_cnt_q     <= viol_cnt_d;
    end
  end

  assign lock_mask    = lock_mask_q;
  assign enable_write = enable_write_q;
  assign busy         = (state_q == BURST);
  assign done         = done_q;
  assign viol         = viol_q;
  assign abort        = abort_q;
  assign viol_cnt     = viol_cnt_q;

endmodule

// File: tb/tb_write_sector_ctrl.sv
// Scoreboard bench for write_sector_ctrl: a 16-sector and a 12-sector
// instance driven with directed and random bursts.
module tb_write_sector_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en_write   [2];
  logic        req_valid  [2];
  logic [3:0]  req_sector [2];
  logic [3:0]  req_len    [2];
  logic        lock_we    [2];
  logic [15:0] lock_in    [2];

  logic        req_ready [2];
  logic        busy      [2];
  logic        done      [2];
  logic        viol      [2];
  logic        abort     [2];
  logic [7:0]  vcnt      [2];
  logic [15:0] lock_mask [2];
  logic [15:0] ew        [2];

  logic [15:0] lm_a, ew_a;
  logic [11:0] lm_b, ew_b;

  always_comb begin
    lock_mask[0] = lm_a;
    lock_mask[1] = {4'b0, lm_b};
    ew[0]        = ew_a;
    ew[1]        = {4'b0, ew_b};
  end

  write_sector_ctrl #(.N_SECTORS(16), .LEN_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_write(en_write[0]), .req_valid(req_valid[0]),
    .req_ready(req_ready[0]), .req_sector(req_sector[0]), .req_len(req_len[0]),
    .lock_we(lock_we[0]), .lock_mask_in(lock_in[0]), .lock_mask(lm_a),
    .enable_write(ew_a), .busy(busy[0]), .done(done[0]), .viol(viol[0]),
    .viol_cnt(vcnt[0]), .abort(abort[0])
  );

  write_sector_ctrl #(.N_SECTORS(12), .LEN_W(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_write(en_write[1]), .req_valid(req_valid[1]),
    .req_ready(req_ready[1]), .req_sector(req_sector[1]), .req_len(req_len[1]),
    .lock_we(lock_we[1]), .lock_mask_in(lock_in[1][11:0]), .lock_mask(lm_b),
    .enable_write(ew_b), .busy(busy[1]), .done(done[1]), .viol(viol[1]),
    .viol_cnt(vcnt[1]), .abort(abort[1])
  );

  typedef struct packed {
    logic [15:0] ew;
    logic        viol;
    logic        done;
    logic        abort;
    logic [7:0]  cnt;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt[2];
  logic [15:0] mmask[2];

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference: one expected output event per visible beat/violation/abort.
  task automatic push(int d, logic [15:0] e, logic v, logic dn, logic ab);
    evt_t ev;
    if (v) mcnt[d] = (mcnt[d] >= 255) ? 255 : mcnt[d] + 1;
    ev.ew = e; ev.viol = v; ev.done = dn; ev.abort = ab; ev.cnt = 8'(mcnt[d]);
    if (d == 0) q0.push_back(ev); else q1.push_back(ev);
  endtask

  function automatic int nsec(int d);
    return (d == 0) ? 16 : 12;
  endfunction

  // Burst of len+1 beats from s, visiting (s+k) mod N; abort_m>0 cuts it
  // after abort_m beats.
  task automatic model_req(int d, int s, int len, int abort_m);
    int n, beats, sec;
    n = nsec(d);
    if (s >= n) begin
      push(d, 16'h0, 1'b1, 1'b0, 1'b0);
    end else begin
      beats = (abort_m > 0) ? abort_m : len + 1;
      for (int k = 0; k < beats; k++) begin
        sec = (s + k) % n;
        push(d, mmask[d][sec] ? 16'h0 : (16'h1 << sec), mmask[d][sec],
             (abort_m == 0) && (k == len), 1'b0);
      end
      if (abort_m > 0) push(d, 16'h0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Monitor: pop and compare whenever a DUT presents an output event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ew[d] != 16'h0 || viol[d] || done[d] || abort[d]) begin
          evt_t ev;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got ew=0x%0h viol=%0b done=%0b abort=%0b, expected no event",
                     d, ew[d], viol[d], done[d], abort[d]);
          end else begin
            ev = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("enable_write", d, 32'(ew[d]), 32'(ev.ew));
            chk("viol", d, 32'(viol[d]), 32'(ev.viol));
            chk("done", d, 32'(done[d]), 32'(ev.done));
            chk("abort", d, 32'(abort[d]), 32'(ev.abort));
            chk("viol_cnt", d, 32'(vcnt[d]), 32'(ev.cnt));
            chk("onehot0", d, 32'($onehot0(ew[d])), 32'd1);
          end
        end
      end
    end
  end

  task automatic set_lock(int d, logic [15:0] m);
    logic [15:0] mm;
    mm = (d == 0) ? m : (m & 16'h0FFF);
    lock_in[d] = mm;
    lock_we[d] = 1'b1;
    @(posedge clk); #1;
    lock_we[d] = 1'b0;
    mmask[d] = mm;
    chk("lock_mask", d, 32'(lock_mask[d]), 32'(mm));
  endtask

  task automatic issue(int d, int s, int len, int abort_m);
    int t;
    logic [15:0] first;
    t = 0;
    en_write[d] = 1'b1;
    while (!req_ready[d] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_idle", d, 32'(req_ready[d]), 32'd1);
    first = mmask[d][s] ? 16'h0 : (16'h1 << s);
    model_req(d, s, len, abort_m);
    req_sector[d] = 4'(s);
    req_len[d]    = 4'(len);
    req_valid[d]  = 1'b1;
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    if (s >= nsec(d)) begin
      chk("bad_start_busy", d, 32'(busy[d]), 32'd0);
      return;
    end
    chk("first_beat", d, 32'(ew[d]), 32'(first));
    if (len > 0 && abort_m == 0) begin
      chk("busy_mid", d, 32'(busy[d]), 32'd1);
      chk("ready_mid", d, 32'(req_ready[d]), 32'd0);
    end
    if (abort_m > 0) begin
      repeat (abort_m - 1) @(posedge clk);
      #1;
      en_write[d] = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", d, 32'(busy[d]), 32'd0);
      @(posedge clk); #1;
      en_write[d] = 1'b1;
    end else begin
      repeat (len + 1) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s, len, ab;
    for (int d = 0; d < 2; d++) begin
      en_write[d] = 1'b0; req_valid[d] = 1'b0; req_sector[d] = '0;
      req_len[d] = '0; lock_we[d] = 1'b0; lock_in[d] = '0;
      mcnt[d] = 0; mmask[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_write[0] = 1'b1;
    en_write[1] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, 32'(req_ready[d]), 32'd1);
      chk("rst_ew", d, 32'(ew[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_flags", d, 32'({done[d], viol[d], abort[d]}), 32'd0);
      chk("rst_cnt", d, 32'(vcnt[d]), 32'd0);
      chk("rst_lock", d, 32'(lock_mask[d]), 32'd0);
    end

    // Directed cases on the 16-sector instance.
    issue(0, 11, 0, 0);
    issue(0, 15, 0, 0);
    issue(0, 14, 3, 0);
    set_lock(0, 16'h0004);
    issue(0, 1, 2, 0);
    set_lock(0, 16'h0000);
    issue(0, 0, 7, 3);

    // Reset mid-burst: only the beats seen before reset are expected.
    set_lock(0, 16'h0100);
    push(0, 16'h0008, 1'b0, 1'b0, 1'b0);
    push(0, 16'h0010, 1'b0, 1'b0, 1'b0);
    req_sector[0] = 4'd3; req_len[0] = 4'd7; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #6;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ew", 0, 32'(ew[0]), 32'd0);
    chk("rstmid_busy", 0, 32'(busy[0]), 32'd0);
    chk("rstmid_lock", 0, 32'(lock_mask[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mmask[d] = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_cnt", 0, 32'(vcnt[0]), 32'd0);

    // Random bursts on the 16-sector instance.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_lock(0, 16'($urandom & $urandom));
      s   = $urandom_range(0, 15);
      len = $urandom_range(0, 15);
      ab  = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      issue(0, s, len, ab);
    end

    // 12-sector instance: invalid start and wrap, then random.
    issue(1, 13, 0, 0);
    issue(1, 11, 1, 0);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) set_lock(1, 16'($urandom & $urandom));
      s   = $urandom_range(0, 15);
      len = $urandom_range(0, 15);
      ab  = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len) : 0;
      issue(1, s, len, ab);
    end

    // Saturation: more than 255 locked beats.
    set_lock(0, 16'hFFFF);
    for (int i = 0; i < 19; i++) issue(0, $urandom_range(0, 15), 15, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("viol_cnt_sat", 0, 32'(vcnt[0]), 32'd255);
    chk("q0_empty", 0, 32'(q0.size()), 32'd0);
    chk("q1_empty", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
